// File: rtl/pipe_skid_stage_if.sv
// Handshake bundle between an upstream producer, the skid stage and a downstream consumer.
interface pipe_skid_stage_if #(
  parameter int unsigned DW = 32
) ();
  localparam int unsigned LVL_W = 2;

  logic             flush_i;
  logic             in_valid_i;
  logic             in_ready_o;
  logic [DW-1:0]    in_data_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [DW-1:0]    out_data_o;
  logic [LVL_W-1:0] level_o;

  // Stage side: consumes upstream payload and downstream ready.
  modport slave (
    input  flush_i, in_valid_i, in_data_i, out_ready_i,
    output in_ready_o, out_valid_o, out_data_o, level_o
  );

  // Environment side: drives payload, flush and downstream ready.
  modport master (
    output flush_i, in_valid_i, in_data_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_data_o, level_o
  );
endinterface

// File: rtl/pipe_skid_stage.sv
// Pipeline stage register with valid/ready handshake, 2-entry skid buffer and flush.
// All handshake outputs come straight from flops, so out_ready_i never reaches in_ready_o
// combinationally.
module pipe_skid_stage #(
  parameter int unsigned   DW      = 32,
  parameter logic [DW-1:0] DEF_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  pipe_skid_stage_if.slave  bus
);

  localparam int unsigned LVL_W = 2;

  // Encoding doubles as the occupancy count.
  typedef enum logic [LVL_W-1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t        r_state;
  logic [DW-1:0] r_main;
  logic [DW-1:0] r_skid;
  logic          r_in_ready;
  logic          r_out_valid;

  state_t        w_state_nxt;
  logic [DW-1:0] w_main_nxt;
  logic [DW-1:0] w_skid_nxt;
  logic          w_acc;
  logic          w_pop;

  assign w_acc = bus.in_valid_i & r_in_ready & ~bus.flush_i;
  assign w_pop = r_out_valid & bus.out_ready_i;

  // Next-state and storage update; flush empties everything and blocks acceptance.
  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;
    if (bus.flush_i) begin
      w_state_nxt = S_EMPTY;
      w_main_nxt  = DEF_VAL;
      w_skid_nxt  = DEF_VAL;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_acc) begin
            w_main_nxt  = bus.in_data_i;
            w_state_nxt = S_ONE;
          end
        end
        S_ONE: begin
          if (w_acc && w_pop) begin
            w_main_nxt = bus.in_data_i;
          end else if (w_acc) begin
            w_skid_nxt  = bus.in_data_i;
            w_state_nxt = S_TWO;
          end else if (w_pop) begin
            w_main_nxt  = DEF_VAL;
            w_state_nxt = S_EMPTY;
          end
        end
        S_TWO: begin
          if (w_pop) begin
            w_main_nxt  = r_skid;
            w_skid_nxt  = DEF_VAL;
            w_state_nxt = S_ONE;
          end
        end
        default: begin
          w_state_nxt = S_EMPTY;
          w_main_nxt  = DEF_VAL;
          w_skid_nxt  = DEF_VAL;
        end
      endcase
    end
  end

  // State, storage and registered handshake flags; reset clears content immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_EMPTY;
      r_main      <= DEF_VAL;
      r_skid      <= DEF_VAL;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_main      <= w_main_nxt;
      r_skid      <= w_skid_nxt;
      r_in_ready  <= (w_state_nxt != S_TWO);
      r_out_valid <= (w_state_nxt != S_EMPTY);
    end
  end

  assign bus.in_ready_o  = r_in_ready;
  assign bus.out_valid_o = r_out_valid;
  assign bus.out_data_o  = r_main;
  assign bus.level_o     = r_state;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed bench for pipe_skid_stage plus a short randomized scoreboard run.
module tb_pipe_skid_stage;

  localparam int unsigned   DW  = 32;
  localparam logic [DW-1:0] DEF = 32'h0000_0013;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  pipe_skid_stage_if #(.DW(DW)) bus ();

  pipe_skid_stage #(.DW(DW), .DEF_VAL(DEF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Check all four observable outputs at once.
  task automatic check_all(input string tag, input logic v, input logic [DW-1:0] d,
                           input logic [1:0] lvl, input logic rdy);
    check({tag, ".valid"}, DW'(bus.out_valid_o), DW'(v));
    check({tag, ".data"},  bus.out_data_o,       d);
    check({tag, ".level"}, DW'(bus.level_o),     DW'(lvl));
    check({tag, ".ready"}, DW'(bus.in_ready_o),  DW'(rdy));
  endtask

  // Advance one clock; inputs are changed and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [DW-1:0] q[$];
  logic [DW-1:0] exp_d;
  logic          m_acc;
  logic          m_pop;
  bit            seen_c0;

  initial begin
    n_vec = 0;
    n_err = 0;
    seen_c0 = 1'b0;
    rst = 1'b1;
    bus.flush_i     = 1'b0;
    bus.in_valid_i  = 1'b0;
    bus.in_data_i   = '0;
    bus.out_ready_i = 1'b0;
    #1;
    check_all("reset", 1'b0, DEF, 2'd0, 1'b1);
    step();
    step();
    rst = 1'b0;
    step();
    check_all("post_reset", 1'b0, DEF, 2'd0, 1'b1);

    // Passthrough: one value per cycle, each visible the cycle after its accept.
    bus.out_ready_i = 1'b1;
    bus.in_valid_i  = 1'b1;
    bus.in_data_i   = 32'hA0;
    step();
    check_all("pass_a0", 1'b1, 32'hA0, 2'd1, 1'b1);
    bus.in_data_i = 32'hA1;
    step();
    check_all("pass_a1", 1'b1, 32'hA1, 2'd1, 1'b1);
    bus.in_data_i = 32'hA2;
    step();
    check_all("pass_a2", 1'b1, 32'hA2, 2'd1, 1'b1);
    bus.in_valid_i = 1'b0;
    step();
    check_all("pass_drain", 1'b0, DEF, 2'd0, 1'b1);

    // Stall: two accepts with downstream blocked fill main then skid.
    bus.out_ready_i = 1'b0;
    bus.in_valid_i  = 1'b1;
    bus.in_data_i   = 32'hB0;
    step();
    check_all("stall_b0", 1'b1, 32'hB0, 2'd1, 1'b1);
    bus.in_data_i = 32'hB1;
    step();
    check_all("stall_full", 1'b1, 32'hB0, 2'd2, 1'b0);
    // Ready must not follow out_ready_i within the cycle.
    bus.in_data_i   = 32'hBF;
    bus.out_ready_i = 1'b1;
    #1;
    check("no_comb_ready", DW'(bus.in_ready_o), DW'(1'b0));
    bus.in_valid_i = 1'b0;
    step();
    check_all("release_b1", 1'b1, 32'hB1, 2'd1, 1'b1);
    step();
    check_all("release_empty", 1'b0, DEF, 2'd0, 1'b1);

    // Flush from TWO with a simultaneous incoming payload.
    bus.out_ready_i = 1'b0;
    bus.in_valid_i  = 1'b1;
    bus.in_data_i   = 32'hD0;
    step();
    bus.in_data_i = 32'hD1;
    step();
    check("flush_pre_level", DW'(bus.level_o), DW'(2'd2));
    bus.flush_i   = 1'b1;
    bus.in_data_i = 32'hC0;
    step();
    check_all("flush", 1'b0, DEF, 2'd0, 1'b1);
    bus.flush_i     = 1'b0;
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b1;
    step();
    check_all("flush_after", 1'b0, DEF, 2'd0, 1'b1);

    // Flush in EMPTY with a valid payload: nothing is accepted.
    bus.flush_i    = 1'b1;
    bus.in_valid_i = 1'b1;
    bus.in_data_i  = 32'hC1;
    step();
    check_all("flush_empty", 1'b0, DEF, 2'd0, 1'b1);
    bus.flush_i    = 1'b0;
    bus.in_valid_i = 1'b0;

    // Async reset between edges while one payload is held.
    bus.out_ready_i = 1'b0;
    bus.in_valid_i  = 1'b1;
    bus.in_data_i   = 32'hE0;
    step();
    bus.in_valid_i = 1'b0;
    check_all("pre_reset", 1'b1, 32'hE0, 2'd1, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check_all("async_reset", 1'b0, DEF, 2'd0, 1'b1);
    step();
    rst = 1'b0;
    bus.in_valid_i = 1'b1;
    bus.in_data_i  = 32'hE1;
    step();
    check_all("reset_recover", 1'b1, 32'hE1, 2'd1, 1'b1);
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b1;
    step();
    check_all("reset_drain", 1'b0, DEF, 2'd0, 1'b1);

    // Randomized traffic against a queue model with occasional flushes.
    q.delete();
    for (int i = 0; i < 600; i++) begin
      bus.in_valid_i  = 1'($urandom_range(0, 1));
      bus.out_ready_i = 1'($urandom_range(0, 1));
      bus.flush_i     = ($urandom_range(0, 31) == 0);
      bus.in_data_i   = $urandom;
      m_pop = (q.size() != 0) && bus.out_ready_i;
      m_acc = bus.in_valid_i && (q.size() < 2) && !bus.flush_i;
      if (bus.in_data_i == 32'hC0) seen_c0 = 1'b1;
      if (bus.flush_i) begin
        q.delete();
      end else begin
        if (m_pop) void'(q.pop_front());
        if (m_acc) q.push_back(bus.in_data_i);
      end
      step();
      exp_d = (q.size() != 0) ? q[0] : DEF;
      check("rnd.valid", DW'(bus.out_valid_o), DW'(q.size() != 0));
      check("rnd.data",  bus.out_data_o, exp_d);
      check("rnd.level", DW'(bus.level_o), DW'(q.size()));
      check("rnd.ready", DW'(bus.in_ready_o), DW'(q.size() < 2));
      if (!seen_c0) check("rnd.no_c0", DW'(bus.out_data_o == 32'hC0), DW'(1'b0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
